// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared parameters and types for the regfile writeback arbiter
package regfile_pkg;
  localparam int NUM_REGS = 32;
  localparam int DATA_W   = 64;
  localparam int ZERO_REG = 31;

  typedef logic [4:0] reg_idx_t;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } gnt_e;
endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - pending-write busy bits with one set port, one clear port, two lookups
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int N  = regfile_pkg::NUM_REGS,
  parameter int ZR = regfile_pkg::ZERO_REG
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     i_set_valid,
  input  reg_idx_t i_set_reg,
  input  logic     i_clr_valid,
  input  reg_idx_t i_clr_reg,
  input  reg_idx_t i_rd1_reg,
  output logic     o_rd1_busy,
  input  reg_idx_t i_rd2_reg,
  output logic     o_rd2_busy
);

  logic [N-1:0] w_busy;

  for (genvar i = 0; i < N; i++) begin : g_busy
    if (i == ZR) begin : g_zero
      assign w_busy[i] = 1'b0;
    end else begin : g_bit
      logic r_bit;
      // A reservation landing on the same edge as the retiring write must survive.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_bit <= 1'b0;
        end else if (i_set_valid && (i_set_reg == reg_idx_t'(i))) begin
          r_bit <= 1'b1;
        end else if (i_clr_valid && (i_clr_reg == reg_idx_t'(i))) begin
          r_bit <= 1'b0;
        end
      end
      assign w_busy[i] = r_bit;
    end
  end

  assign o_rd1_busy = w_busy[i_rd1_reg];
  assign o_rd2_busy = w_busy[i_rd2_reg];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin ALU/load writeback arbiter feeding the regfile write port
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [4:0]        a_reg,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [4:0]        b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              rsv_valid,
  input  logic [4:0]        rsv_reg,
  output logic              RegWrite,
  output logic [4:0]        WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  input  logic [4:0]        ReadRegister1,
  input  logic [4:0]        ReadRegister2,
  output logic              busy1,
  output logic              busy2
);

  localparam reg_idx_t ZR = reg_idx_t'(ZERO_REG);

  gnt_e              r_last_gnt;
  logic              r_reg_write;
  reg_idx_t          r_write_reg;
  logic [DATA_W-1:0] r_write_data;

  logic w_a_ready;
  logic w_b_ready;
  logic w_hs_a;
  logic w_hs_b;

  // Grant depends only on valids and the last winner, never on reg or data.
  always_comb begin
    w_a_ready = 1'b0;
    w_b_ready = 1'b0;
    if (reset) begin
      if (a_valid && (!b_valid || (r_last_gnt == GNT_B))) begin
        w_a_ready = 1'b1;
      end else if (b_valid) begin
        w_b_ready = 1'b1;
      end
    end
  end

  assign w_hs_a = a_valid && w_a_ready;
  assign w_hs_b = b_valid && w_b_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_gnt <= GNT_B;
    end else if (w_hs_a) begin
      r_last_gnt <= GNT_A;
    end else if (w_hs_b) begin
      r_last_gnt <= GNT_B;
    end
  end

  // Writes to the zero register are accepted but never raise the write enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_reg_write  <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
    end else if (w_hs_a) begin
      r_reg_write  <= (a_reg != ZR);
      r_write_reg  <= a_reg;
      r_write_data <= a_data;
    end else if (w_hs_b) begin
      r_reg_write  <= (b_reg != ZR);
      r_write_reg  <= b_reg;
      r_write_data <= b_data;
    end else begin
      r_reg_write  <= 1'b0;
    end
  end

  regfile_scoreboard #(
    .N  (NUM_REGS),
    .ZR (ZERO_REG)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .i_set_valid (rsv_valid),
    .i_set_reg   (rsv_reg),
    .i_clr_valid (r_reg_write),
    .i_clr_reg   (r_write_reg),
    .i_rd1_reg   (ReadRegister1),
    .o_rd1_busy  (busy1),
    .i_rd2_reg   (ReadRegister2),
    .o_rd2_busy  (busy2)
  );

  assign a_ready       = w_a_ready;
  assign b_ready       = w_b_ready;
  assign RegWrite      = r_reg_write;
  assign WriteRegister = r_write_reg;
  assign WriteData     = r_write_data;

endmodule
